// File: rtl/weight_read_sequencer.sv
// Weight-memory read sequencer for one neuron: pairs each accepted activation
// with the weight fetched from a 1-cycle-latency ROM and hands the pair to the MAC.
module weight_read_sequencer #(
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [addressWidth:0] base_addr,
  input  logic [addressWidth:0] num_weights,
  output logic                  busy,
  output logic                  done,
  input  logic                  x_valid,
  input  logic [dataWidth-1:0]  x_data,
  output logic                  x_ready,
  output logic                  w_ren,
  output logic [addressWidth:0] w_raddr,
  input  logic [dataWidth-1:0]  w_rdata,
  output logic                  mac_valid,
  output logic [dataWidth-1:0]  mac_x,
  output logic [dataWidth-1:0]  mac_w,
  output logic                  mac_last
);

  localparam int AW = addressWidth + 1;
  localparam logic [AW-1:0] ONE = AW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state;
  logic [AW-1:0] base_reg;
  logic [AW-1:0] num_reg;
  logic [AW-1:0] cnt;
  logic          hs;
  logic          last_hs;

  // The ROM read is issued in the handshake cycle so its data lines up with
  // the registered activation one cycle later.
  assign hs      = x_valid & x_ready;
  assign last_hs = hs && (cnt == (num_reg - ONE));
  assign w_ren   = hs;
  assign w_raddr = base_reg + cnt;
  assign mac_w   = w_rdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      base_reg  <= '0;
      num_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      x_ready   <= 1'b0;
      mac_valid <= 1'b0;
      mac_last  <= 1'b0;
      mac_x     <= '0;
    end else begin
      done      <= 1'b0;
      mac_valid <= hs;
      mac_last  <= last_hs;
      if (hs) begin
        mac_x <= x_data;
        cnt   <= cnt + ONE;
      end
      case (state)
        IDLE: begin
          if (start) begin
            if (num_weights != '0) begin
              base_reg <= base_addr;
              num_reg  <= num_weights;
              cnt      <= '0;
              busy     <= 1'b1;
              x_ready  <= 1'b1;
              state    <= RUN;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        RUN: begin
          if (last_hs) begin
            x_ready <= 1'b0;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_read_sequencer.sv
// Randomized directed bench for weight_read_sequencer against a pass-level
// reference model (accepted-input count, expected address and pair queues).
module tb_weight_read_sequencer;

  localparam int AW = 11;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] num_weights;
  logic          busy;
  logic          done;
  logic          x_valid;
  logic [DW-1:0] x_data;
  logic          x_ready;
  logic          w_ren;
  logic [AW-1:0] w_raddr;
  logic [DW-1:0] w_rdata;
  logic          mac_valid;
  logic [DW-1:0] mac_x;
  logic [DW-1:0] mac_w;
  logic          mac_last;

  logic [DW-1:0] rom [0:2047];

  int checks = 0;
  int errors = 0;

  weight_read_sequencer #(.addressWidth(10), .dataWidth(DW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
    .num_weights(num_weights), .busy(busy), .done(done), .x_valid(x_valid),
    .x_data(x_data), .x_ready(x_ready), .w_ren(w_ren), .w_raddr(w_raddr),
    .w_rdata(w_rdata), .mac_valid(mac_valid), .mac_x(mac_x), .mac_w(mac_w),
    .mac_last(mac_last)
  );

  always #5 clk = ~clk;

  // Behavioural single-port ROM with one cycle of read latency.
  always @(posedge clk) begin
    if (w_ren) w_rdata <= rom[w_raddr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_x_ready"}, 32'(x_ready), 0);
    check({tag, "_w_ren"}, 32'(w_ren), 0);
    check({tag, "_mac_valid"}, 32'(mac_valid), 0);
    check({tag, "_mac_last"}, 32'(mac_last), 0);
    check({tag, "_mac_x"}, 32'(mac_x), 0);
  endtask

  // mode 0: x_valid always high, x = 1,2,3...; mode 1: x_valid follows 1,0,0,1,0,1
  // then stays high; mode 2: random gaps with gap_pct percent probability.
  task automatic run_pass(input logic [AW-1:0] base, input logic [AW-1:0] num,
                          input int mode, input int gap_pct, input int abort_after,
                          input bit mid_start);
    int            accepted = 0;
    int            cyc = 0;
    int            wren_seen = 0;
    bit            running, drain_now, done_now, pending, pend_last, hs, xv, fin;
    bit [5:0]      pat = 6'b101001;
    logic [DW-1:0] pend_x, pend_w;
    logic [AW-1:0] addr;

    start = 1'b1; base_addr = base; num_weights = num; x_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; base_addr = AW'($urandom); num_weights = AW'($urandom);
    running = (num != 0); drain_now = 1'b0; done_now = (num == 0);
    pending = 1'b0; pend_last = 1'b0; pend_x = '0; pend_w = '0; fin = 1'b0;

    while (!fin && cyc < 400) begin
      if (abort_after >= 0 && accepted == abort_after) begin
        x_valid = 1'b1;
        #2 rstn = 1'b0;
        #1 check_all_zero("abort_async");
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) begin
          @(negedge clk);
          #1;
          check("abort_no_done", 32'(done), 0);
          check("abort_x_ready", 32'(x_ready), 0);
          check("abort_w_ren", 32'(w_ren), 0);
          check("abort_mac_valid", 32'(mac_valid), 0);
        end
        x_valid = 1'b0;
        $display("pass base=%0d num=%0d aborted after %0d inputs", base, num, accepted);
        return;
      end

      check("mac_valid", 32'(mac_valid), 32'(pending));
      if (pending) begin
        check("mac_x", 32'(mac_x), 32'(pend_x));
        check("mac_w", 32'(mac_w), 32'(pend_w));
        check("mac_last", 32'(mac_last), 32'(pend_last));
      end else begin
        check("mac_last_idle", 32'(mac_last), 0);
      end
      check("x_ready", 32'(x_ready), 32'(running));
      check("busy", 32'(busy), 32'(running || drain_now));
      check("done", 32'(done), 32'(done_now));
      if (done_now) fin = 1'b1;

      case (mode)
        0:       xv = 1'b1;
        1:       xv = (cyc < 6) ? pat[cyc] : 1'b1;
        default: xv = ($urandom_range(99) >= gap_pct);
      endcase
      x_valid = xv;
      x_data  = (mode == 0) ? DW'(accepted + 1) : DW'($urandom);
      if (fin) begin
        start = 1'b1; num_weights = 3;
      end else if (mid_start && accepted == 2 && running) begin
        start = 1'b1; num_weights = 5; base_addr = base + AW'(100);
      end else begin
        start = 1'b0;
      end
      #1;
      hs   = xv && running;
      addr = base + AW'(accepted);
      check("w_ren", 32'(w_ren), 32'(hs));
      if (w_ren) wren_seen++;
      if (hs) check("w_raddr", 32'(w_raddr), 32'(addr));

      done_now = drain_now;
      pending  = hs;
      if (hs) begin
        pend_x    = x_data;
        pend_w    = rom[addr];
        pend_last = (accepted == int'(num) - 1);
        accepted++;
        if (accepted == int'(num)) running = 1'b0;
      end
      drain_now = hs && pend_last;
      @(negedge clk);
      cyc++;
    end

    check("pass_complete", 32'(fin), 1);
    check("w_ren_count", 32'(wren_seen), 32'(num));
    check("start_in_done_ignored", 32'(x_ready), 0);
    check("post_done", 32'(done), 0);
    check("post_busy", 32'(busy), 0);
    start = 1'b0; x_valid = 1'b0;
    $display("pass base=%0d num=%0d mode=%0d cycles=%0d reads=%0d", base, num, mode, cyc, wren_seen);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; base_addr = '0; num_weights = '0;
    x_valid = 1'b0; x_data = '0;
    for (int i = 0; i < 2048; i++) rom[i] = DW'($urandom);

    #12 check_all_zero("reset");
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      x_valid = 1'b1;
      #1;
      check("idle_x_ready", 32'(x_ready), 0);
      check("idle_w_ren", 32'(w_ren), 0);
    end
    x_valid = 1'b0;
    @(negedge clk);

    run_pass(11'd0, 11'd4, 0, 0, -1, 1'b0);
    run_pass(11'd5, 11'd3, 1, 0, -1, 1'b0);
    run_pass(11'd2046, 11'd4, 2, 0, -1, 1'b0);
    run_pass(11'd77, 11'd0, 2, 50, -1, 1'b0);
    run_pass(11'd40, 11'd7, 2, 30, -1, 1'b1);
    run_pass(11'd100, 11'd8, 0, 0, 2, 1'b0);
    @(negedge clk);
    run_pass(11'd16, 11'd2, 0, 0, -1, 1'b0);
    for (int p = 0; p < 6; p++) begin
      run_pass(AW'($urandom), AW'($urandom_range(24, 1)), 2, 40, -1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/weight_read_sequencer.md
Name: weight_read_sequencer

Overview:
- Sequences one neuron's weight-memory read pass against an incoming activation stream.
- On each accepted input it issues a read to a single-port, 1-cycle-latency weight ROM and presents the aligned (x, w) pair to the downstream MAC with a last flag.
- Sits between the layer input stream and one neuron's weight memory and MAC; one instance per neuron.

Parameters:
- addressWidth, 10, weight-memory address width; read address bus is addressWidth+1 bits.
- dataWidth, 16, width of activations and weights.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins a pass; sampled only in IDLE.
- base_addr  in  addressWidth+1  first weight address; captured on start.
- num_weights  in  addressWidth+1  number of weights/inputs in the pass; captured on start.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when the pass completes.
- x_valid  in  1  input activation valid.
- x_data  in  dataWidth  input activation.
- x_ready  out  1  input accept; high only in RUN.
- w_ren  out  1  weight memory read enable.
- w_raddr  out  addressWidth+1  weight memory read address.
- w_rdata  in  dataWidth  weight memory read data, valid 1 cycle after w_ren.
- mac_valid  out  1  (mac_x, mac_w) pair valid.
- mac_x  out  dataWidth  aligned activation.
- mac_w  out  dataWidth  weight; driven combinationally from w_rdata.
- mac_last  out  1  marks the final pair of the pass; qualified by mac_valid.

Behaviour:
- Reset (async, rstn=0): state=IDLE, cnt=0, addr register=0, done=0, busy=0, x_ready=0, mac_valid=0, mac_last=0, mac_x=0. Reset mid-pass aborts the pass; no done is produced.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start with num_weights!=0: capture base_addr and num_weights, cnt=0, go to RUN.
  - On start with num_weights==0: go to DONE directly. No reads, no mac_valid.
- RUN:
  - x_ready=1.
  - Handshake is x_valid & x_ready. In a handshake cycle, w_ren=1 and w_raddr=base+cnt (combinational). These are the only cycles with w_ren=1.
  - Address arithmetic is modulo 2^(addressWidth+1); it wraps silently.
  - On each handshake, register x_data into mac_x and advance cnt.
  - Next cycle after a handshake: mac_valid=1, mac_w=w_rdata.
  - Handshake with cnt==num_weights-1: set mac_last for the following cycle, go to DRAIN.
  - Gaps in x_valid produce mac_valid=0 bubbles; the pass does not stall or time out.
- DRAIN: x_ready=0. The final pair is presented (mac_valid=1, mac_last=1). Go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Latency: handshake at cycle N gives mac_valid at N+1. A pass of K inputs with no gaps completes with done at cycle start+K+2.
- busy is 1 in RUN and DRAIN only.
- start is ignored outside IDLE. base_addr and num_weights are ignored except at start.
- A start coinciding with DONE is ignored.
- mac_last is never high without mac_valid.

Test Plan:
- Reset then idle: rstn low mid-stream -> all outputs 0 immediately (async). After release: x_ready=0 and w_ren=0 until start.
- Basic pass: base=0, num=4, x_valid held high with x=1,2,3,4 -> w_raddr 0,1,2,3 on consecutive cycles; mac pairs (1,w0)..(4,w3); mac_last only on the 4th pair; done one cycle after it; exactly 4 w_ren pulses.
- Bubbles: num=3, x_valid pattern 1,0,0,1,0,1 -> 3 mac_valid pulses each 1 cycle after its handshake; mac_last on the third; w_raddr increments only on handshakes.
- Wrap: base=2046, num=4 (addressWidth=10) -> w_raddr 2046,2047,0,1.
- Zero length and ignored start: num=0 -> done 1 cycle after start, no w_ren. A start pulsed during RUN with num=5 -> no change in captured length or addresses.
- Abort: rstn asserted after 2 of 8 inputs -> no done. A new start with base=16, num=2 then behaves as a clean pass from address 16.
